// File: rtl/alu_execute_stage_pkg.sv
// Shared encodings for the ALU control code and the operand forward selects.
// The decoder produces these same values, so both sides import this package.
package alu_execute_stage_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // 11 is not a distinct source; it falls back to the register operand.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_execute_stage_alu_core.sv
// Combinational ALU: add/sub/and/or/slt with signed overflow, zero and
// illegal-code detection.
module alu_core
  import alu_execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             less;

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  assign ovf_add = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
  assign ovf_sub = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
  // Correcting the difference sign by the overflow bit gives an exact signed compare.
  assign less    = diff[WIDTH-1] ^ ovf_sub;

  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        result = sum;
        ovf    = ovf_add;
      end
      ALU_SUB: begin
        result = diff;
        ovf    = ovf_sub;
      end
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, less};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_execute_stage.sv
// EX stage: operand forwarding, immediate select, ALU and the EX/MEM register
// with stall (hold) and flush (bubble) control.
module alu_execute_stage
  import alu_execute_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2:0]         ALUCONTROL,
  input  logic [WIDTH-1:0]   RD1_E,
  input  logic [WIDTH-1:0]   RD2_E,
  input  logic [WIDTH-1:0]   SIGNIMM_E,
  input  logic               ALUSRC_E,
  input  logic [1:0]         FWDA_E,
  input  logic [1:0]         FWDB_E,
  input  logic [WIDTH-1:0]   RESULT_W,
  input  logic [REGADDR-1:0] WRITEREG_E,
  input  logic               REGWRITE_E,
  input  logic               MEMWRITE_E,
  input  logic               MEMTOREG_E,
  input  logic               VALID_E,
  input  logic               STALL_M,
  input  logic               FLUSH_M,
  output logic [WIDTH-1:0]   ALURESULT_M,
  output logic [WIDTH-1:0]   WRITEDATA_M,
  output logic [REGADDR-1:0] WRITEREG_M,
  output logic               REGWRITE_M,
  output logic               MEMWRITE_M,
  output logic               MEMTOREG_M,
  output logic               VALID_M,
  output logic               ZERO_M,
  output logic               OVF_M,
  output logic               ILLEGAL_M
);

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_ovf;
  logic             alu_illegal;

  // FWD_MEM reads the registered result, so during a stall it sees the held value.
  always_comb begin
    case (FWDA_E)
      FWD_WB:  src_a = RESULT_W;
      FWD_MEM: src_a = ALURESULT_M;
      default: src_a = RD1_E;
    endcase
    case (FWDB_E)
      FWD_WB:  fwd_b = RESULT_W;
      FWD_MEM: fwd_b = ALURESULT_M;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSRC_E ? SIGNIMM_E : fwd_b;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (ALUCONTROL),
    .result      (alu_result),
    .zero        (alu_zero),
    .ovf         (alu_ovf),
    .illegal     (alu_illegal)
  );

  // Priority per edge: reset, then flush, then stall, then load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALURESULT_M <= '0;
      WRITEDATA_M <= '0;
      WRITEREG_M  <= '0;
      REGWRITE_M  <= 1'b0;
      MEMWRITE_M  <= 1'b0;
      MEMTOREG_M  <= 1'b0;
      VALID_M     <= 1'b0;
      ZERO_M      <= 1'b0;
      OVF_M       <= 1'b0;
      ILLEGAL_M   <= 1'b0;
    end else if (FLUSH_M) begin
      ALURESULT_M <= '0;
      WRITEDATA_M <= '0;
      WRITEREG_M  <= '0;
      REGWRITE_M  <= 1'b0;
      MEMWRITE_M  <= 1'b0;
      MEMTOREG_M  <= 1'b0;
      VALID_M     <= 1'b0;
      ZERO_M      <= 1'b0;
      OVF_M       <= 1'b0;
      ILLEGAL_M   <= 1'b0;
    end else if (!STALL_M) begin
      ALURESULT_M <= alu_result;
      WRITEDATA_M <= fwd_b;
      WRITEREG_M  <= WRITEREG_E;
      REGWRITE_M  <= REGWRITE_E;
      MEMWRITE_M  <= MEMWRITE_E;
      MEMTOREG_M  <= MEMTOREG_E;
      VALID_M     <= VALID_E;
      ZERO_M      <= alu_zero;
      OVF_M       <= alu_ovf;
      ILLEGAL_M   <= alu_illegal;
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for alu_execute_stage: vector table plus hand-written
// reset, forwarding, stall and flush sequences.
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  alucontrol = '0;
  logic [31:0] rd1 = '0, rd2 = '0, signimm = '0, result_w = '0;
  logic        alusrc = 1'b0;
  logic [1:0]  fwda = '0, fwdb = '0;
  logic [4:0]  writereg_e = '0;
  logic        regwrite_e = 1'b0, memwrite_e = 1'b0, memtoreg_e = 1'b0, valid_e = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;

  logic [31:0] aluresult_m, writedata_m;
  logic [4:0]  writereg_m;
  logic        regwrite_m, memwrite_m, memtoreg_m, valid_m, zero_m, ovf_m, illegal_m;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_execute_stage #(.WIDTH(32), .REGADDR(5)) dut (
    .CLK(clk), .RST(rst), .ALUCONTROL(alucontrol),
    .RD1_E(rd1), .RD2_E(rd2), .SIGNIMM_E(signimm), .ALUSRC_E(alusrc),
    .FWDA_E(fwda), .FWDB_E(fwdb), .RESULT_W(result_w),
    .WRITEREG_E(writereg_e), .REGWRITE_E(regwrite_e), .MEMWRITE_E(memwrite_e),
    .MEMTOREG_E(memtoreg_e), .VALID_E(valid_e),
    .STALL_M(stall), .FLUSH_M(flush),
    .ALURESULT_M(aluresult_m), .WRITEDATA_M(writedata_m), .WRITEREG_M(writereg_m),
    .REGWRITE_M(regwrite_m), .MEMWRITE_M(memwrite_m), .MEMTOREG_M(memtoreg_m),
    .VALID_M(valid_m), .ZERO_M(zero_m), .OVF_M(ovf_m), .ILLEGAL_M(illegal_m)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, mw, mt, vl, z, o, il;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, imm, wb;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] e_res, e_wd;
    logic        e_z, e_o, e_il;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input string name, input logic [2:0] op,
                              input logic [31:0] a, b, imm, wb, input logic src,
                              input logic [1:0] fa, fb, input logic [31:0] e_res, e_wd,
                              input logic e_z, e_o, e_il);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.imm = imm; v.wb = wb; v.src = src;
    v.fa = fa; v.fb = fb; v.e_res = e_res; v.e_wd = e_wd;
    v.e_z = e_z; v.e_o = e_o; v.e_il = e_il;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input exp_t e);
    check({name, ".aluresult"}, aluresult_m, e.res);
    check({name, ".writedata"}, writedata_m, e.wd);
    check({name, ".writereg"},  {27'd0, writereg_m}, {27'd0, e.wr});
    check({name, ".regwrite"},  {31'd0, regwrite_m}, {31'd0, e.rw});
    check({name, ".memwrite"},  {31'd0, memwrite_m}, {31'd0, e.mw});
    check({name, ".memtoreg"},  {31'd0, memtoreg_m}, {31'd0, e.mt});
    check({name, ".valid"},     {31'd0, valid_m},    {31'd0, e.vl});
    check({name, ".zero"},      {31'd0, zero_m},     {31'd0, e.z});
    check({name, ".ovf"},       {31'd0, ovf_m},      {31'd0, e.o});
    check({name, ".illegal"},   {31'd0, illegal_m},  {31'd0, e.il});
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.res = '0; e.wd = '0; e.wr = '0;
    e.rw = 0; e.mw = 0; e.mt = 0; e.vl = 0; e.z = 0; e.o = 0; e.il = 0;
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, b, imm, wb,
                       input logic src, input logic [1:0] fa, fb,
                       input logic [4:0] wr, input logic rw, mw, mt, vl);
    alucontrol = op; rd1 = a; rd2 = b; signimm = imm; result_w = wb;
    alusrc = src; fwda = fa; fwdb = fb;
    writereg_e = wr; regwrite_e = rw; memwrite_e = mw; memtoreg_e = mt; valid_e = vl;
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e, held;

    vecs[0]  = mk("add_ovf",  3'b010, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 2'b00, 2'b00, 32'h80000000, 32'h1, 0, 1, 0);
    vecs[1]  = mk("sub_ovf",  3'b110, 32'h80000000, 32'h1, 0, 0, 0, 2'b00, 2'b00, 32'h7FFFFFFF, 32'h1, 0, 1, 0);
    vecs[2]  = mk("sub_zero", 3'b110, 32'd5, 32'd5, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'd5, 1, 0, 0);
    vecs[3]  = mk("sub_neg",  3'b110, 32'd3, 32'd5, 0, 0, 0, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd5, 0, 0, 0);
    vecs[4]  = mk("slt_neg",  3'b111, 32'h80000000, 32'h1, 0, 0, 0, 2'b00, 2'b00, 32'h1, 32'h1, 0, 0, 0);
    vecs[5]  = mk("slt_ovf",  3'b111, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'hFFFFFFFF, 1, 0, 0);
    vecs[6]  = mk("slt_eq",   3'b111, 32'd3, 32'd3, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'd3, 1, 0, 0);
    vecs[7]  = mk("and",      3'b000, 32'hF0F01234, 32'h0FF0FFFF, 0, 0, 0, 2'b00, 2'b00, 32'h00F01234, 32'h0FF0FFFF, 0, 0, 0);
    vecs[8]  = mk("or",       3'b001, 32'hF0000000, 32'h0000000F, 0, 0, 0, 2'b00, 2'b00, 32'hF000000F, 32'h0000000F, 0, 0, 0);
    vecs[9]  = mk("ill_100",  3'b100, 32'd5, 32'd5, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'd5, 1, 0, 1);
    vecs[10] = mk("ill_011",  3'b011, 32'd1, 32'd2, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'd2, 1, 0, 1);
    vecs[11] = mk("ill_101",  3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'hFFFFFFFF, 1, 0, 1);
    vecs[12] = mk("imm",      3'b010, 32'd100, 32'h55, 32'hFFFFFFFC, 0, 1, 2'b00, 2'b00, 32'h60, 32'h55, 0, 0, 0);
    vecs[13] = mk("fwd_b_wb", 3'b010, 32'd1, 32'hDEAD, 0, 32'h1234, 0, 2'b00, 2'b01, 32'h1235, 32'h1234, 0, 0, 0);
    vecs[14] = mk("fwd_11",   3'b010, 32'd7, 32'd8, 0, 32'h999, 0, 2'b11, 2'b11, 32'hF, 32'd8, 0, 0, 0);
    vecs[15] = mk("fwd_a_wb", 3'b001, 32'd0, 32'd0, 0, 32'hA5, 0, 2'b01, 2'b00, 32'hA5, 32'd0, 0, 0, 0);
    vecs[16] = mk("add_wrap", 3'b010, 32'h80000000, 32'h80000000, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'h80000000, 1, 1, 0);

    // Reset applied away from any edge must clear outputs at once.
    #1 rst = 1'b1;
    #1 check_all("reset", zero_exp());
    step();
    check_all("reset_held", zero_exp());
    @(negedge clk) rst = 1'b0;

    // Table: control pass-through bits are derived from the vector index.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].wb, vecs[i].src,
            vecs[i].fa, vecs[i].fb, 5'(i + 1), i[0], i[1], i[2], 1'b1);
      step();
      e.res = vecs[i].e_res; e.wd = vecs[i].e_wd; e.wr = 5'(i + 1);
      e.rw = i[0]; e.mw = i[1]; e.mt = i[2]; e.vl = 1'b1;
      e.z = vecs[i].e_z; e.o = vecs[i].e_o; e.il = vecs[i].e_il;
      check_all(vecs[i].name, e);
    end

    // Forward from EX/MEM (0x10) and writeback (0x20).
    drive(3'b010, 32'h10, 32'h0, 0, 0, 0, 2'b00, 2'b00, 5'd3, 1, 0, 0, 1);
    step();
    check("fwd_seed", aluresult_m, 32'h10);
    drive(3'b010, 32'h0, 32'h0, 0, 32'h20, 0, 2'b10, 2'b01, 5'd4, 1, 0, 0, 1);
    step();
    e = zero_exp(); e.res = 32'h30; e.wd = 32'h20; e.wr = 5'd4; e.rw = 1; e.vl = 1;
    check_all("fwd_mem_wb", e);
    drive(3'b010, 32'h10, 32'h0, 0, 0, 0, 2'b00, 2'b00, 5'd3, 1, 0, 0, 1);
    step();
    drive(3'b010, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h20, 1, 2'b10, 2'b01, 5'd5, 1, 0, 0, 1);
    step();
    e = zero_exp(); e.res = 32'h0F; e.wd = 32'h20; e.wr = 5'd5; e.rw = 1; e.vl = 1;
    check_all("fwd_imm", e);

    // Stall for three cycles holds everything; then forward the held value.
    drive(3'b010, 32'd1, 32'd2, 0, 0, 0, 2'b00, 2'b00, 5'd9, 1, 1, 1, 1);
    step();
    held = zero_exp(); held.res = 32'd3; held.wd = 32'd2; held.wr = 5'd9;
    held.rw = 1; held.mw = 1; held.mt = 1; held.vl = 1;
    check_all("pre_stall", held);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(3'b001, 32'hFFFF0000, 32'h0000FFFF, 0, 0, 0, 2'b00, 2'b00, 5'd17, 0, 0, 0, 0);
      step();
      check_all($sformatf("stall_%0d", c), held);
    end
    drive(3'b010, 32'h0, 32'd1, 0, 0, 0, 2'b10, 2'b00, 5'd10, 1, 0, 0, 1);
    stall = 1'b0;
    step();
    e = zero_exp(); e.res = 32'd4; e.wd = 32'd1; e.wr = 5'd10; e.rw = 1; e.vl = 1;
    check_all("post_stall_fwd", e);

    // Flush wins over stall.
    drive(3'b010, 32'd7, 32'd7, 0, 0, 0, 2'b00, 2'b00, 5'd11, 1, 1, 1, 1);
    stall = 1'b1; flush = 1'b1;
    step();
    check_all("flush_stall", zero_exp());
    stall = 1'b0; flush = 1'b0;

    // Reset mid-stream with VALID_M high, then a clean load after release.
    drive(3'b000, 32'hFF, 32'h0F, 0, 0, 0, 2'b00, 2'b00, 5'd12, 1, 0, 1, 1);
    step();
    check("mid_valid", {31'd0, valid_m}, 32'd1);
    #2 rst = 1'b1;
    #1 check_all("mid_reset", zero_exp());
    step();
    check_all("mid_reset_edge", zero_exp());
    @(negedge clk) rst = 1'b0;
    drive(3'b110, 32'd10, 32'd3, 0, 0, 0, 2'b00, 2'b00, 5'd13, 1, 0, 0, 1);
    step();
    e = zero_exp(); e.res = 32'd7; e.wd = 32'd3; e.wr = 5'd13; e.rw = 1; e.vl = 1;
    check_all("after_reset", e);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
